// File: rtl/crank_cam_gen.sv
// Crank/cam trigger-wheel generator: emits a TEETH-MISSING VR tooth pattern with a
// stretched gap tooth, plus a two-revolution cam phase signal, at a programmable speed.
module crank_cam_gen #(
  parameter int unsigned TEETH       = 60,
  parameter int unsigned MISSING     = 2,
  parameter int unsigned TICKS       = 64,
  parameter int unsigned START_TOOTH = 53,
  parameter int unsigned CAM_TOGGLE  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] presc,
  input  logic [5:0] cam_fall,
  input  logic [5:0] cam_rise,
  output logic       vr,
  output logic       cam,
  output logic       phase,
  output logic [5:0] tooth,
  output logic       gap,
  output logic       rev_strobe
);

  localparam int unsigned GapTopI = TICKS * (MISSING + 1) - 1;
  localparam int unsigned TckW    = $clog2(GapTopI + 1);

  localparam logic [TckW-1:0] NormTop    = TckW'(TICKS - 1);
  localparam logic [TckW-1:0] GapTop     = TckW'(GapTopI);
  localparam logic [5:0]      LastTooth  = 6'(TEETH - MISSING - 1);
  localparam logic [5:0]      StartTooth = 6'(START_TOOTH);
  localparam logic [5:0]      CamToggle  = 6'(CAM_TOGGLE);

  logic [7:0]      presc_l_q, presc_l_d;
  logic [7:0]      scnt_q, scnt_d;
  logic [TckW-1:0] tckc_q, tckc_d;
  logic [5:0]      tooth_q, tooth_d;
  logic            vr_q, vr_d;
  logic            cam_q, cam_d;
  logic            phase_q, phase_d;
  logic            rev_q, rev_d;

  logic [TckW-1:0] top;
  logic            tick;

  always_comb begin
    presc_l_d = presc_l_q;
    scnt_d    = scnt_q;
    tckc_d    = tckc_q;
    tooth_d   = tooth_q;
    vr_d      = vr_q;
    cam_d     = cam_q;
    phase_d   = phase_q;
    rev_d     = 1'b0;
    top       = (tooth_q == LastTooth) ? GapTop : NormTop;
    tick      = (scnt_q == presc_l_q);

    if (!en) begin
      // Idle keeps tracking presc so a start uses the value present at that time.
      presc_l_d = presc;
      scnt_d    = '0;
      tckc_d    = '0;
      vr_d      = 1'b0;
      tooth_d   = StartTooth;
    end else if (!tick) begin
      scnt_d = scnt_q + 8'd1;
    end else begin
      scnt_d = '0;
      if (tckc_q != top) begin
        if (tckc_q == (top >> 1)) begin
          vr_d = 1'b1;
        end
        tckc_d = tckc_q + TckW'(1);
      end else begin
        tckc_d = '0;
        vr_d   = 1'b0;
        if (tooth_q == LastTooth) begin
          tooth_d   = '0;
          rev_d     = 1'b1;
          presc_l_d = presc;
        end else begin
          tooth_d = tooth_q + 6'd1;
        end
        if (tooth_q == CamToggle) begin
          phase_d = ~phase_q;
        end
        // Cam edges look at the pre-toggle phase; rise is evaluated last so it wins a tie.
        if (phase_q && (tooth_q == cam_fall)) begin
          cam_d = 1'b0;
        end
        if (phase_q && (tooth_q == cam_rise)) begin
          cam_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_l_q <= '0;
      scnt_q    <= '0;
      tckc_q    <= '0;
      tooth_q   <= StartTooth;
      vr_q      <= 1'b0;
      cam_q     <= 1'b1;
      phase_q   <= 1'b0;
      rev_q     <= 1'b0;
    end else begin
      presc_l_q <= presc_l_d;
      scnt_q    <= scnt_d;
      tckc_q    <= tckc_d;
      tooth_q   <= tooth_d;
      vr_q      <= vr_d;
      cam_q     <= cam_d;
      phase_q   <= phase_d;
      rev_q     <= rev_d;
    end
  end

  assign vr         = vr_q;
  assign cam        = cam_q;
  assign phase      = phase_q;
  assign tooth      = tooth_q;
  assign rev_strobe = rev_q;
  assign gap        = (tooth_q == LastTooth);

endmodule

// File: tb/tb_crank_cam_gen.sv
// Self-checking bench for crank_cam_gen: a clock-count wheel model checked every cycle,
// plus directed duration, sequence and cam-edge checks.
module tb_crank_cam_gen;

  localparam int Last  = 57;
  localparam int Start = 53;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] presc = 8'd15;
  logic [5:0] cam_fall = 6'd54;
  logic [5:0] cam_rise = 6'd4;
  logic       vr, cam, phase, gap, rev_strobe;
  logic [5:0] tooth;
  logic [10:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: clocks elapsed in the current tooth, tooth index, period per sub-tick.
  int m_el = 0;
  int m_p = 1;
  int m_tooth = Start;
  bit m_cam = 1'b1;
  bit m_phase = 1'b0;
  bit m_rev = 1'b0;

  always #5 clk = ~clk;

  crank_cam_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .presc     (presc),
    .cam_fall  (cam_fall),
    .cam_rise  (cam_rise),
    .vr        (vr),
    .cam       (cam),
    .phase     (phase),
    .tooth     (tooth),
    .gap       (gap),
    .rev_strobe(rev_strobe)
  );

  assign dut_vec = {vr, cam, phase, tooth, gap, rev_strobe};

  function automatic int tooth_clocks(int t, int p);
    return ((t == Last) ? 192 : 64) * p;
  endfunction

  function automatic logic [10:0] exp_vec();
    logic mvr;
    mvr = (m_el >= tooth_clocks(m_tooth, m_p) / 2);
    return {mvr, m_cam, m_phase, 6'(m_tooth), m_tooth == Last, m_rev};
  endfunction

  // One clock: advance the model with the inputs present at the edge, then settle.
  task automatic step();
    int t;
    @(posedge clk);
    cyc++;
    if (!en) begin
      m_el = 0;
      m_tooth = Start;
      m_rev = 1'b0;
      m_p = int'(presc) + 1;
    end else begin
      m_rev = 1'b0;
      m_el++;
      if (m_el == tooth_clocks(m_tooth, m_p)) begin
        t = m_tooth;
        m_el = 0;
        if (t == Last) begin
          m_tooth = 0;
          m_rev = 1'b1;
          m_p = int'(presc) + 1;
        end else begin
          m_tooth = t + 1;
        end
        if (m_phase && t == int'(cam_rise)) m_cam = 1'b1;
        else if (m_phase && t == int'(cam_fall)) m_cam = 1'b0;
        if (t == 30) m_phase = ~m_phase;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_el = 0; m_tooth = Start; m_cam = 1'b1; m_phase = 1'b0; m_rev = 1'b0; m_p = 1;
    n_cmp++;
    if (dut_vec !== {1'b0, 1'b1, 1'b0, 6'd53, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state got=%b expected=%b", dut_vec, {1'b0, 1'b1, 1'b0, 6'd53, 2'b00});
    end
    rst = 1'b1;
  endtask

  task automatic test_normal_tooth();
    int fall_c, rise_c, prev_t, seq_i, expd;
    int exp_seq[6] = '{53, 54, 55, 56, 57, 0};
    logic prev_vr;
    bit done;
    presc = 8'd15;
    step();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL idle_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec());
    end
    en = 1'b1;
    fall_c = cyc; rise_c = cyc; prev_vr = 1'b0; prev_t = Start; seq_i = 0; done = 1'b0;
    for (int i = 0; i < 9000 && !done; i++) begin
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL tooth_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec());
      end
      if (vr && !prev_vr) begin
        expd = (int'(tooth) == Last) ? 1536 : 512;
        n_cmp++;
        if (cyc - fall_c != expd) begin
          n_bad++;
          $display("FAIL vr_low_len tooth=%0d got=%0d expected=%0d", tooth, cyc - fall_c, expd);
        end
        rise_c = cyc;
      end
      if (!vr && prev_vr) begin
        expd = (prev_t == Last) ? 1536 : 512;
        n_cmp++;
        if (cyc - rise_c != expd) begin
          n_bad++;
          $display("FAIL vr_high_len tooth=%0d got=%0d expected=%0d", prev_t, cyc - rise_c, expd);
        end
        fall_c = cyc;
      end
      if (int'(tooth) != prev_t) begin
        seq_i++;
        n_cmp++;
        if (seq_i > 5 || int'(tooth) != exp_seq[seq_i]) begin
          n_bad++;
          $display("FAIL tooth_seq step=%0d got=%0d expected=%0d", seq_i, tooth,
                   (seq_i > 5) ? -1 : exp_seq[seq_i]);
        end
      end
      if (rev_strobe) begin
        n_cmp++;
        if (prev_t != Last || tooth != 6'd0) begin
          n_bad++;
          $display("FAIL rev_wrap got=%0d->%0d expected=57->0", prev_t, tooth);
        end
        done = 1'b1;
      end
      prev_vr = vr;
      prev_t = int'(tooth);
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL first_wrap_timeout got=none expected=rev_strobe");
    end
  endtask

  task automatic test_speed_change();
    int start_c, sw, fall_c, prev_t, expd;
    logic prev_vr;
    bit done;
    start_c = cyc; fall_c = cyc; prev_t = 0; prev_vr = 1'b0; done = 1'b0;
    sw = int'($urandom_range(1000, 50000));
    for (int i = 1; i <= 62000 && !done; i++) begin
      if (i == sw) presc = 8'd7;
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL rev_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec());
      end
      if (!vr && prev_vr) begin
        expd = (prev_t == Last) ? 3072 : 1024;
        n_cmp++;
        if (cyc - fall_c != expd) begin
          n_bad++;
          $display("FAIL tooth_period tooth=%0d got=%0d expected=%0d", prev_t, cyc - fall_c, expd);
        end
        fall_c = cyc;
      end
      if (rev_strobe) begin
        n_cmp++;
        if (cyc - start_c != 61440) begin
          n_bad++;
          $display("FAIL rev_period got=%0d expected=61440", cyc - start_c);
        end
        done = 1'b1;
      end
      prev_vr = vr;
      prev_t = int'(tooth);
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL second_wrap_timeout got=none expected=rev_strobe");
    end
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      step();
      if (!vr && prev_vr) begin
        n_cmp++;
        if (cyc - fall_c != 512 || tooth != 6'd1) begin
          n_bad++;
          $display("FAIL fast_tooth0 got=%0d,tooth=%0d expected=512,tooth=1", cyc - fall_c, tooth);
        end
        done = 1'b1;
      end
      prev_vr = vr;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL fast_tooth0_timeout got=none expected=vr_fall");
    end
  endtask

  task automatic test_enable_abort();
    int extra, hold, start_c;
    logic prev_vr;
    bit found, done;
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL abort_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec());
      end
      if (tooth == 6'd10 && vr) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL tooth10_timeout got=none expected=tooth10_high");
    end
    extra = int'($urandom_range(0, 200));
    repeat (extra) step();
    n_cmp++;
    if (!(vr && tooth == 6'd10)) begin
      n_bad++;
      $display("FAIL pre_abort got=vr%0d,tooth=%0d expected=vr1,tooth=10", vr, tooth);
    end
    en = 1'b0;
    step();
    n_cmp++;
    if (vr !== 1'b0 || tooth !== 6'd53) begin
      n_bad++;
      $display("FAIL abort got=vr%0d,tooth=%0d expected=vr0,tooth=53", vr, tooth);
    end
    hold = int'($urandom_range(1, 5));
    repeat (hold) step();
    n_cmp++;
    if (dut_vec !== exp_vec() || tooth !== 6'd53) begin
      n_bad++;
      $display("FAIL idle_hold got=%b expected=%b", dut_vec, exp_vec());
    end
    presc = 8'd15;
    step();
    en = 1'b1;
    start_c = cyc; prev_vr = 1'b0; done = 1'b0;
    for (int i = 0; i < 1100 && !done; i++) begin
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL restart_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec());
      end
      if (vr && !prev_vr) begin
        n_cmp++;
        if (cyc - start_c != 512) begin
          n_bad++;
          $display("FAIL restart_low got=%0d expected=512", cyc - start_c);
        end
      end
      if (!vr && prev_vr) begin
        n_cmp++;
        if (cyc - start_c != 1024 || tooth != 6'd54) begin
          n_bad++;
          $display("FAIL restart_tooth got=%0d,tooth=%0d expected=1024,tooth=54", cyc - start_c,
                   tooth);
        end
        done = 1'b1;
      end
      prev_vr = vr;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL restart_timeout got=none expected=vr_fall");
    end
  endtask

  task automatic test_cam_pattern();
    int toggles, prev_t;
    logic prev_phase, prev_cam;
    en = 1'b0;
    presc = 8'd0;
    cam_fall = 6'd54;
    cam_rise = 6'd4;
    step();
    en = 1'b1;
    toggles = 0; prev_t = Start; prev_phase = phase; prev_cam = cam;
    repeat (8400) begin
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL cam_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec());
      end
      if (phase != prev_phase) begin
        toggles++;
        n_cmp++;
        if (prev_t != 30 || tooth != 6'd31) begin
          n_bad++;
          $display("FAIL phase_toggle got=%0d->%0d expected=30->31", prev_t, tooth);
        end
      end
      if (cam != prev_cam) begin
        n_cmp++;
        if (!prev_phase || (cam ? prev_t != 4 : prev_t != 54)) begin
          n_bad++;
          $display("FAIL cam_edge got=cam%0d,tooth=%0d,phase=%0d expected=%s", cam, prev_t,
                   prev_phase, cam ? "rise@4,phase1" : "fall@54,phase1");
        end
      end
      prev_t = int'(tooth);
      prev_phase = phase;
      prev_cam = cam;
    end
    n_cmp++;
    if (toggles != 2) begin
      n_bad++;
      $display("FAIL phase_toggle_count got=%0d expected=2", toggles);
    end
  endtask

  task automatic test_cam_random();
    logic [5:0] r;
    r = 6'($urandom_range(0, 57));
    en = 1'b0;
    cam_fall = r;
    cam_rise = r;
    step();
    en = 1'b1;
    repeat (4000) begin
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL cam_tie_model r=%0d cyc=%0d got=%b expected=%b", r, cyc, dut_vec, exp_vec());
      end
    end
    cam_fall = 6'($urandom_range(0, 57));
    cam_rise = 6'($urandom_range(0, 57));
    presc = 8'($urandom_range(0, 3));
    repeat (1500) begin
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL cam_rand_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (vr && tooth != 6'd53) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL async_setup_timeout got=none expected=vr_high");
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== {1'b0, 1'b1, 1'b0, 6'd53, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset got=%b expected=%b", dut_vec, {1'b0, 1'b1, 1'b0, 6'd53, 2'b00});
    end
    en = 1'b0;
    m_el = 0; m_tooth = Start; m_cam = 1'b1; m_phase = 1'b0; m_rev = 1'b0; m_p = 1;
    #1 rst = 1'b1;
    step();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL post_reset_model got=%b expected=%b", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_normal_tooth();
    test_speed_change();
    test_enable_abort();
    test_cam_pattern();
    test_cam_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
